rect_stream_out: RTL and testbench
==================================

RECT_STREAM_OUT -- requirements
Module: rect_stream_out

Interface
REQ-001 Parameter IMG_WIDTH, default 640, pixels per line.
REQ-002 Parameter IMG_HEIGHT, default 480, lines per frame.
REQ-003 Parameter FIFO_DEPTH, default 16, power of two (min 4), buffer entries.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 recpixel  input  8  rectified pixel from interpolator.
REQ-007 recvalid  input  1  pixel valid; no ready exists, so the pixel must be taken or dropped that cycle.
REQ-008 reclast  input  1  end-of-line marker, qualified by recvalid.
REQ-009 m_tdata  output  8  AXI4-Stream video pixel.
REQ-010 m_tvalid  output  1  output beat valid.
REQ-011 m_tready  input  1  downstream ready.
REQ-012 m_tlast  output  1  end of line (EOL).
REQ-013 m_tuser  output  1  start of frame (SOF).
REQ-014 fill  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-015 overflow  output  1  sticky: a pixel has been dropped.
REQ-016 drop_cnt  output  16  dropped-pixel count (see Configuration).

Function
REQ-017 Input side SHALL keep in_col and in_row counters that advance on every recvalid beat, including dropped beats.
REQ-018 in_col SHALL clear on a reclast beat and otherwise increment; in_row SHALL increment on a reclast beat and wrap IMG_HEIGHT-1 -> 0.
REQ-019 Each FIFO entry SHALL be {sof, eol, pixel}, 10 bits, with sof = (in_col==0 && in_row==0) and eol = reclast.
REQ-020 Input FSM SHALL have two states, RUN and DROP; it SHALL reset to RUN.
REQ-021 In RUN, a recvalid beat SHALL be written unless the FIFO is full with no pop that cycle.
- Full with a simultaneous pop: the write is accepted and fill is unchanged.
REQ-022 A RUN beat that cannot be written SHALL be dropped, set overflow, and move the FSM to DROP.
REQ-023 In DROP, all beats SHALL be discarded.
- Exit to RUN after the reclast beat with in_row==IMG_HEIGHT-1 (end of input frame).
- The next frame therefore restarts cleanly at SOF.
REQ-024 Output SHALL present the FIFO head: m_tvalid = (fill != 0), m_tdata/m_tlast/m_tuser = the head entry's pixel/eol/sof.
REQ-025 A pop SHALL occur only on m_tvalid && m_tready.
- While m_tvalid is high and no pop occurs, m_tdata/m_tlast/m_tuser SHALL hold stable.
REQ-026 Latency: a pixel written into an empty FIFO at edge N SHALL appear on the output (m_tvalid high) after edge N+1.
REQ-027 Read/write pointers SHALL wrap modulo FIFO_DEPTH.
- Full is fill==FIFO_DEPTH; empty is fill==0.
- Pop when empty and push when full-without-pop SHALL never corrupt the pointers.
REQ-028 overflow SHALL stay set until reset; it has no effect on the output side, which drains the already-buffered entries normally.

Reset
REQ-029 While rst is low at a clock edge, the block SHALL:
- clear pointers, fill, in_col, in_row, overflow and drop_cnt;
- set the FSM to RUN;
- drive m_tvalid=0, m_tlast=0, m_tuser=0, m_tdata=0.
REQ-030 Reset mid-frame SHALL discard buffered data; the first recvalid beat after reset is treated as col 0 / row 0 (SOF).

Configuration
REQ-031 With macro RECT_DROP_CNT_EN defined:
- drop_cnt SHALL increment on every discarded beat (RUN overflow beat and every DROP beat);
- it saturates at 16'hFFFF.
REQ-032 Without RECT_DROP_CNT_EN, drop_cnt SHALL be tied to 0 and no counter logic is built; all other behaviour is identical.

Verification
REQ-033 Reset, then IMG_WIDTH=4, IMG_HEIGHT=2, m_tready=1, feed 8 beats with pixels 0..7 and reclast on beats 3 and 7 -> output pixels 0..7; tuser on pixel 0 only; tlast on pixels 3 and 7; no overflow.
REQ-034 FIFO_DEPTH=4, m_tready=0, feed 5 beats -> fill=4; overflow=1 on the 5th beat; FSM in DROP; drop_cnt=1 (macro on) or 0 (macro off).
REQ-035 Continue from REQ-034 until the last reclast of the frame, then release m_tready and send a new frame -> the 4 buffered pixels drain, then the new frame starts with tuser=1 and is complete.
REQ-036 FIFO full, m_tready=1 and recvalid in the same cycle -> no drop; fill stays 4; overflow stays 0.
REQ-037 m_tready toggled randomly 50% over 3 frames with continuous input and FIFO_DEPTH large enough -> every pixel output in order; output data held stable while stalled.
REQ-038 rst low for one cycle mid-line -> m_tvalid=0 next cycle; the next input beat is output with tuser=1.

Source files
------------

// File: rtl/rect_stream_out_if.sv
// Pixel handshake bundle: rectifier-side input beat (valid only, no ready) and AXI4-Stream video output.
interface rect_stream_out_if;
  logic [7:0] recpixel;
  logic       recvalid;
  logic       reclast;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready;
  logic       m_tlast;
  logic       m_tuser;

  modport master (
    input  recpixel, recvalid, reclast, m_tready,
    output m_tdata, m_tvalid, m_tlast, m_tuser
  );

  modport slave (
    output recpixel, recvalid, reclast, m_tready,
    input  m_tdata, m_tvalid, m_tlast, m_tuser
  );
endinterface

// File: rtl/rect_stream_out.sv
// Buffers rectified pixels into an AXI4-Stream video output; on overflow drops the rest of the frame.
// Output is registered (one cycle after the write); define RECT_DROP_CNT_EN for a saturating drop counter.
module rect_stream_out #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  rect_stream_out_if.master             strm,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          overflow,
  output logic [15:0]                   drop_cnt
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int FW    = AW + 1;
  localparam int COL_W = $clog2(IMG_WIDTH) + 1;
  localparam int ROW_W = $clog2(IMG_HEIGHT) + 1;

  typedef struct packed {
    logic       sof;
    logic       eol;
    logic [7:0] pixel;
  } entry_t;

  typedef enum logic {RUN = 1'b0, DROP = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic [COL_W-1:0]  in_col_q, in_col_d;
  logic [ROW_W-1:0]  in_row_q, in_row_d;
  logic              overflow_q, overflow_d;
  logic              m_tvalid_q, m_tvalid_d;
  logic [7:0]        m_tdata_q, m_tdata_d;
  logic              m_tlast_q, m_tlast_d;
  logic              m_tuser_q, m_tuser_d;

  entry_t            mem_q [FIFO_DEPTH];
  entry_t            wr_entry;
  entry_t            head;
  logic              pop, push, drop, full, last_row, frame_end;
  logic [FW-1:0]     avail;

  always_comb begin
    pop       = m_tvalid_q && strm.m_tready;
    full      = (fill_q == FW'(FIFO_DEPTH));
    push      = strm.recvalid && (state_q == RUN) && (!full || pop);
    drop      = strm.recvalid && !push;
    last_row  = (in_row_q == ROW_W'(IMG_HEIGHT - 1));
    frame_end = strm.recvalid && strm.reclast && last_row;

    wr_entry.sof   = (in_col_q == '0) && (in_row_q == '0);
    wr_entry.eol   = strm.reclast;
    wr_entry.pixel = strm.recpixel;

    // Position counters track every beat, dropped or not, so SOF stays aligned to the source.
    in_col_d = in_col_q;
    in_row_d = in_row_q;
    if (strm.recvalid) begin
      if (strm.reclast) begin
        in_col_d = '0;
        in_row_d = last_row ? '0 : in_row_q + ROW_W'(1);
      end else begin
        in_col_d = in_col_q + COL_W'(1);
      end
    end

    // A dropped beat that itself closes the frame leaves nothing left to discard.
    state_d = state_q;
    case (state_q)
      RUN:     if (drop && !frame_end) state_d = DROP;
      DROP:    if (frame_end)          state_d = RUN;
      default: state_d = RUN;
    endcase

    overflow_d = overflow_q | drop;
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    fill_d     = fill_q + FW'(push) - FW'(pop);

    // Present only entries written before this edge, giving the one-cycle write-to-output latency.
    avail      = fill_q - FW'(pop);
    head       = mem_q[rd_ptr_d];
    m_tvalid_d = (avail != '0);
    m_tdata_d  = m_tvalid_d ? head.pixel : 8'h00;
    m_tlast_d  = m_tvalid_d && head.eol;
    m_tuser_d  = m_tvalid_d && head.sof;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      in_col_q   <= '0;
      in_row_q   <= '0;
      overflow_q <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= 8'h00;
      m_tlast_q  <= 1'b0;
      m_tuser_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      in_col_q   <= in_col_d;
      in_row_q   <= in_row_d;
      overflow_q <= overflow_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tlast_q  <= m_tlast_d;
      m_tuser_q  <= m_tuser_d;
    end
  end

`ifdef RECT_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) drop_cnt_q <= 16'h0000;
    else      drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 16'h0000;
`endif

  assign strm.m_tvalid = m_tvalid_q;
  assign strm.m_tdata  = m_tdata_q;
  assign strm.m_tlast  = m_tlast_q;
  assign strm.m_tuser  = m_tuser_q;
  assign fill          = fill_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_rect_stream_out.sv
// Directed bench for rect_stream_out: a depth-4 instance for overflow/full cases, a depth-32 one for random stalls.
module tb_rect_stream_out;

`ifdef RECT_DROP_CNT_EN
  localparam int DC_EN = 1;
`else
  localparam int DC_EN = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rect_stream_out_if i4 ();
  rect_stream_out_if i32 ();

  logic [2:0]  fill4;
  logic [5:0]  fill32;
  logic        ovf4, ovf32;
  logic [15:0] dc4, dc32;

  rect_stream_out #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .FIFO_DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .strm(i4), .fill(fill4), .overflow(ovf4), .drop_cnt(dc4)
  );

  rect_stream_out #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .FIFO_DEPTH(32)) dut32 (
    .clk(clk), .rst(rst), .strm(i32), .fill(fill32), .overflow(ovf32), .drop_cnt(dc32)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  logic [9:0] q4[$];
  logic [9:0] q32[$];
  logic [9:0] ex[$];
  logic       prev_stall = 1'b0;
  logic [9:0] prev_ent = '0;

  // Capture handshakes and check output stability on the stalled instance, mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (i4.m_tvalid && i4.m_tready) q4.push_back({i4.m_tuser, i4.m_tlast, i4.m_tdata});
      if (i32.m_tvalid && i32.m_tready) q32.push_back({i32.m_tuser, i32.m_tlast, i32.m_tdata});
      if (prev_stall) chk("hold32", int'({i32.m_tvalid, i32.m_tuser, i32.m_tlast, i32.m_tdata}),
                          int'({1'b1, prev_ent}));
      prev_stall = i32.m_tvalid && !i32.m_tready;
      prev_ent   = {i32.m_tuser, i32.m_tlast, i32.m_tdata};
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic logic [9:0] ent(input logic u, input logic l, input logic [7:0] d);
    return {u, l, d};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [7:0] p, input logic l);
    i4.recvalid = v;  i4.recpixel = p;  i4.reclast = l;
    i32.recvalid = v; i32.recpixel = p; i32.reclast = l;
  endtask

  task automatic set_rdy(input logic r4, input logic r32);
    i4.m_tready = r4;
    i32.m_tready = r32;
  endtask

  task automatic beat(input logic [7:0] p, input logic l);
    set_in(1'b1, p, l);
    cyc();
    set_in(1'b0, 8'h00, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_in(1'b0, 8'h00, 1'b0);
    cyc();
    cyc();
    q4.delete();
    q32.delete();
    rst = 1'b1;
  endtask

  task automatic cmp_q(input string tag, input bit big);
    int n;
    n = big ? q32.size() : q4.size();
    chk({tag, "_count"}, n, ex.size());
    for (int i = 0; i < ex.size() && i < n; i++)
      chk($sformatf("%s_beat%0d", tag, i), int'(big ? q32[i] : q4[i]), int'(ex[i]));
  endtask

  initial begin
    set_rdy(1'b1, 1'b1);
    do_reset();

    // Reset state, sampled while reset is still asserted.
    rst = 1'b0;
    cyc();
    chk("rst_tvalid", int'(i4.m_tvalid), 0);
    chk("rst_tuser", int'(i4.m_tuser), 0);
    chk("rst_tlast", int'(i4.m_tlast), 0);
    chk("rst_tdata", int'(i4.m_tdata), 0);
    chk("rst_fill", int'(fill4), 0);
    chk("rst_overflow", int'(ovf4), 0);
    chk("rst_drop_cnt", int'(dc4), 0);
    chk("rst_state", int'(dut4.state_q), 0);
    rst = 1'b1;

    // One 4x2 frame with ready held high, including first-beat latency.
    beat(8'd0, 1'b0);
    chk("lat_edge_n", int'(i4.m_tvalid), 0);
    beat(8'd1, 1'b0);
    chk("lat_edge_n1_valid", int'(i4.m_tvalid), 1);
    chk("lat_edge_n1_data", int'(i4.m_tdata), 0);
    chk("lat_edge_n1_user", int'(i4.m_tuser), 1);
    for (int i = 2; i < 8; i++) beat(8'(i), (i == 3) || (i == 7));
    idle(8);
    ex.delete();
    for (int i = 0; i < 8; i++) ex.push_back(ent(i == 0, (i == 3) || (i == 7), 8'(i)));
    cmp_q("frame4", 1'b0);
    cmp_q("frame32", 1'b1);
    chk("frame_overflow", int'(ovf4), 0);

    // Overflow with ready low, drop to end of frame, then a clean frame.
    do_reset();
    set_rdy(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) beat(8'(10 + i), i == 3);
    chk("ovf_fill_full", int'(fill4), 4);
    chk("ovf_before", int'(ovf4), 0);
    beat(8'd14, 1'b0);
    chk("ovf_fill", int'(fill4), 4);
    chk("ovf_flag", int'(ovf4), 1);
    chk("ovf_state_drop", int'(dut4.state_q), 1);
    chk("ovf_drop_cnt", int'(dc4), DC_EN);
    beat(8'd15, 1'b0);
    beat(8'd16, 1'b0);
    beat(8'd17, 1'b1);
    chk("drop_fill", int'(fill4), 4);
    chk("drop_state_run", int'(dut4.state_q), 0);
    chk("drop_cnt_total", int'(dc4), 4 * DC_EN);
    chk("drop_no_output", q4.size(), 0);
    set_rdy(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) beat(8'(20 + i), (i == 3) || (i == 7));
    idle(12);
    ex.delete();
    for (int i = 0; i < 4; i++) ex.push_back(ent(i == 0, i == 3, 8'(10 + i)));
    for (int i = 0; i < 8; i++) ex.push_back(ent(i == 0, (i == 3) || (i == 7), 8'(20 + i)));
    cmp_q("drain", 1'b0);
    chk("drain_overflow_sticky", int'(ovf4), 1);
    chk("drain_fill", int'(fill4), 0);

    // Full FIFO with a pop and a push in the same cycle.
    do_reset();
    set_rdy(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) beat(8'(30 + i), i == 3);
    chk("fullpop_pre_fill", int'(fill4), 4);
    set_rdy(1'b1, 1'b1);
    beat(8'd34, 1'b0);
    chk("fullpop_fill", int'(fill4), 4);
    chk("fullpop_overflow", int'(ovf4), 0);
    idle(8);
    ex.delete();
    for (int i = 0; i < 4; i++) ex.push_back(ent(i == 0, i == 3, 8'(30 + i)));
    ex.push_back(ent(1'b0, 1'b0, 8'd34));
    cmp_q("fullpop", 1'b0);
    chk("fullpop_end_fill", int'(fill4), 0);

    // Three frames of continuous input against a randomly stalling sink.
    do_reset();
    for (int i = 0; i < 24; i++) begin
      set_rdy(1'b1, 1'($urandom_range(0, 1)));
      beat(8'(i * 7 + 3), (i % 4) == 3);
    end
    set_rdy(1'b1, 1'b1);
    idle(40);
    ex.delete();
    for (int i = 0; i < 24; i++) ex.push_back(ent((i % 8) == 0, (i % 4) == 3, 8'(i * 7 + 3)));
    cmp_q("stall", 1'b1);
    chk("stall_overflow", int'(ovf32), 0);

    // One-cycle reset in the middle of a line.
    do_reset();
    beat(8'd40, 1'b0);
    beat(8'd41, 1'b0);
    rst = 1'b0;
    cyc();
    chk("midrst_tvalid", int'(i4.m_tvalid), 0);
    chk("midrst_fill", int'(fill4), 0);
    q4.delete();
    q32.delete();
    rst = 1'b1;
    beat(8'd50, 1'b0);
    idle(5);
    ex.delete();
    ex.push_back(ent(1'b1, 1'b0, 8'd50));
    cmp_q("midrst", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
